multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multicycle sequencer for the RV32I core. It drives a single shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction.
- Decodes the instruction-register fields (opcode, funct3, funct7[5]) and walks an FSM that emits per-state datapath selects and write enables.
- Handles memory wait states through a ready handshake.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the instret counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  instr[6:0] from the instruction register.
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  PC load enable.
- ir_write  output  1  instruction register load enable (also latches old_pc).
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU-out register.
- mem_write  output  1  store strobe.
- reg_write  output  1  register file write enable.
- result_src  output  2  result mux: 00 = ALU-out register, 01 = memory data, 10 = ALU result.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  output  1  one-cycle pulse when an unsupported opcode or funct3 is seen in DECODE.
- state  output  4  current state, for debug.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FETCH, instret=0. While rst_n=0, all write enables (pc_write, ir_write, mem_write, reg_write) and illegal are forced to 0. Selects take their FETCH values.
- Reset asserted mid-instruction aborts the instruction; no further writes occur.
- Outputs are combinational from state, opcode, funct3, zero and mem_ready. Registered state only. Any output not listed for a state is 0.
- States and encoding:
  - FETCH=0
    - adr_src=0, a=00, b=10, add, result_src=10.
    - ir_write=pc_write=mem_ready.
    - If mem_ready: go to DECODE; otherwise stay in FETCH.
  - DECODE=1
    - a=01, b=01, add (precomputes branch target into the ALU-out register).
    - Next state by opcode:
      - 0000011 or 0100011 -> MEMADR.
      - 0110011 -> EXECR.
      - 0010011 -> EXECI.
      - 1101111 -> JAL.
      - 1100011 with funct3 000 or 001 -> BR.
      - Anything else -> FETCH with illegal=1; not counted in instret.
  - MEMADR=2
    - a=10, b=01, add.
    - Go to MEMRD for a load, MEMWR for a store.
  - MEMRD=3
    - adr_src=1.
    - Stay while !mem_ready; go to MEMWB when mem_ready.
  - MEMWB=4
    - result_src=01, reg_write=1.
    - Go to FETCH.
  - MEMWR=5
    - adr_src=1, mem_write=1, held until mem_ready.
    - Go to FETCH on mem_ready.
  - EXECR=6
    - a=10, b=00.
    - alu_control from funct3:
      - 000 -> sub if funct7b5=1, else add.
      - 010 -> slt.
      - 110 -> or.
      - 111 -> and.
      - Others -> add.
    - Go to ALUWB.
  - EXECI=7
    - a=10, b=01.
    - Same funct3 map as EXECR, but never sub.
    - Go to ALUWB.
  - ALUWB=8
    - result_src=00, reg_write=1.
    - Go to FETCH.
  - JAL=9
    - a=01, b=10, add; result_src=00, pc_write=1 (PC <- target held in the ALU-out register).
    - Go to ALUWB (rd <- old_pc+4).
  - BR=10
    - a=10, b=00, sub, result_src=00.
    - pc_write = zero when funct3=000 (beq); pc_write = !zero when funct3=001 (bne).
    - Go to FETCH.
  - Encodings 11-15 are unreachable; if entered, go to FETCH with no write enables asserted.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB or BR. It wraps from all-ones to 0.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.

Test Plan:
- Reset with mem_ready held 1: state=0, instret=0, all enables 0. Release rst_n -> next edge state=1; ir_write=pc_write=1 during the FETCH cycle.
- add (0110011, f3=000, f7b5=0) then sub (f7b5=1), mem_ready=1: visits 0,1,6,8,0. alu_control=000 then 001 in EXECR; reg_write=1 only in ALUWB; instret goes 0->1->2.
- lw with mem_ready low for 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0. adr_src=1 throughout MEMRD; reg_write with result_src=01 in MEMWB.
- sw with mem_ready=0 for 2 cycles: mem_write held 1 for 3 cycles in state 5, then FETCH; instret +1.
- beq: zero=1 -> pc_write=1 in BR; zero=0 -> pc_write=0. bne inverts both. Each retires one instruction.
- Illegal opcode 0000000 -> illegal=1 for one cycle in DECODE, back to FETCH, instret unchanged. Assert rst_n=0 in MEMRD -> state=0 immediately (asynchronous).

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: walks one FSM per instruction, driving the shared ALU,
// the unified memory port and the register file, and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_JAL    = 4'd9;
    localparam logic [3:0] S_BR     = 4'd10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic use_sub);
        logic [2:0] op;
        case (f3)
            3'b000:  op = use_sub ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_s;
    logic             br_ok_s;
    logic             pc_write_s, ir_write_s, mem_write_s, reg_write_s, illegal_s;

    assign br_ok_s = (funct3 == 3'b000) || (funct3 == 3'b001);

    // State register and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state selection; retire_s marks the edges that complete an instruction
    always_comb begin
        state_d  = S_FETCH;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BR: begin
                        if (br_ok_s) state_d = S_BR;
                        else         state_d = S_FETCH;
                    end
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LOAD) state_d = S_MEMRD;
                else                   state_d = S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
                else           state_d = S_MEMRD;
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_EXECR: state_d = S_ALUWB;
            S_EXECI: state_d = S_ALUWB;
            S_ALUWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_JAL:   state_d = S_ALUWB;
            S_BR: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (retire_s) instret_d = instret_q + CNT_W'(1);
        else          instret_d = instret_q;
    end

    // Per-state datapath selects and write enables
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL: illegal_s = 1'b0;
                    OP_BR:   illegal_s = !br_ok_s;
                    default: illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMRD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7b5);
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, 1'b0);
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
            end
            S_BR: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                if (funct3 == 3'b000)      pc_write_s = zero;
                else if (funct3 == 3'b001) pc_write_s = !zero;
                else                       pc_write_s = 1'b0;
            end
            default: begin
                adr_src = 1'b0;
            end
        endcase
    end

    // Enables are held off combinationally while reset is asserted
    assign pc_write  = pc_write_s  & rst_n;
    assign ir_write  = ir_write_s  & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign illegal   = illegal_s   & rst_n;
    assign state     = state_q;
    assign instret   = instret_q;

endmodule
